vga_sprite_renderer: RTL and testbench
======================================

VGA_SPRITE_RENDERER -- requirements
Module: vga_sprite_renderer

Interface
REQ-001 SHALL have port CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports next_x, next_y  in  10 each  pixel coordinate requested by the downstream VGA timing stage; visible range is 0..639 by 0..479.
REQ-004 SHALL have ports bg_r, bg_g, bg_b  in  8 each  background colour.
REQ-005 SHALL have ports spr_r, spr_g, spr_b  in  8 each  sprite foreground colour.
REQ-006 SHALL have ports bm_we (in, 1), bm_addr (in, 8), bm_data (in, 1)  sprite bitmap write port; the bitmap is 16x16 at 1 bit per pixel, and addr = row*16+col.
REQ-007 SHALL have ports pos_valid (in, 1), pos_ready (out, 1), pos_x (in, 10), pos_y (in, 10)  sprite position update handshake.
REQ-008 SHALL have ports red_in, green_in, blue_in  out  8 each  colour presented to the VGA stage.
REQ-009 SHALL have port frame_cnt  out  8  count of committed frames.

Function
REQ-010 SHALL register next_x/next_y in stage 1, compute colour in stage 2, and present colour exactly 2 CLOCK_50 cycles after coordinate sampling.
REQ-011 SHALL output 0 on all colour channels when the stage-1 coordinate has x>=640 or y>=480.
REQ-012 SHALL treat a pixel as inside the sprite when ax<=x<ax+W and ay<=y<ay+W, with ax/ay the active position, and comparisons done in 11 bits so there is no wrap at the right or bottom edge.
REQ-013 SHALL output spr_* for an inside pixel whose bitmap bit is 1; inside pixels with bit 0, and all outside pixels, SHALL output bg_*.
REQ-014 SHALL, on bm_we, write bm_data into bitmap[bm_addr] on the next edge; a same-cycle read of that address SHALL return the old bit.
REQ-015 SHALL hold pos_ready=1 when no update is pending; on pos_valid&&pos_ready, SHALL capture pos_x/pos_y into the shadow registers, set pending, and drop pos_ready on the next cycle.
REQ-016 SHALL, at the commit point (first cycle with next_y==480 after any cycle with next_y!=480), copy shadow into active position if pending, clear pending, and increment frame_cnt modulo 256 (255->0) regardless of pending.
REQ-017 SHALL, when a handshake and the commit point coincide, commit the previously pending value (if any); the newly captured value SHALL remain pending until the next commit.
REQ-018 SHALL never change the active position outside the commit point, so no tearing occurs within a visible frame.
REQ-019 SHALL clip the sprite silently when the active position places it partly off-screen; positions >=640/480 SHALL render no sprite pixels.

Reset
REQ-020 SHALL, while reset=0, force colour outputs to 0, active and shadow positions to (0,0), pending to 0, frame_cnt to 0, and all pipeline registers to 0.
REQ-021 SHALL clear all bitmap bits to 0 on reset.
REQ-022 SHALL drive pos_ready=1 from the first edge after reset release; a reset during a pending update SHALL discard that update.

Configuration
REQ-023 SHALL, with SPRITE_SCALE2X_EN defined, draw each bitmap bit as a 2x2 block (W=32, bitmap index uses offset>>1).
REQ-024 SHALL, without SPRITE_SCALE2X_EN defined, use W=16 with 1:1 mapping.

Verification
REQ-025 Reset then x=5, y=5, bg=(10,20,30), empty bitmap -> outputs (10,20,30) 2 cycles after sampling; frame_cnt=0 and pos_ready=1.
REQ-026 Write bitmap[0]=1, commit pos (100,50), spr=(255,0,0) -> (100,50) gives (255,0,0); (101,50) gives bg; (116,50) gives bg (W=16).
REQ-027 Handshake pos (200,200) mid-frame -> pos_ready=0 and the old position is still rendered until next_y==480; afterwards the new position is rendered, pos_ready=1, and frame_cnt has incremented.
REQ-028 Pos (630,470) with bitmap all 1 -> x 630..639 and y 470..479 show sprite colour; x=640 shows 0, with no wrap to x=0.
REQ-029 Run 256 commits -> frame_cnt returns to 0; a handshake coinciding with a commit cycle takes effect one frame later.
REQ-030 SPRITE_SCALE2X_EN build, bitmap[0]=1, pos (0,0) -> pixels (0..1, 0..1) show sprite colour; (2,0) shows bg.

Source files
------------

// File: rtl/vga_sprite_renderer.sv
// rtl/vga_sprite_renderer.sv - two-stage sprite-over-background pixel pipeline with frame-synchronous position commit
// Optional macro SPRITE_SCALE2X_EN draws each bitmap bit as a 2x2 block (32x32 sprite).
module vga_sprite_renderer (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic [7:0] bg_r,
  input  logic [7:0] bg_g,
  input  logic [7:0] bg_b,
  input  logic [7:0] spr_r,
  input  logic [7:0] spr_g,
  input  logic [7:0] spr_b,
  input  logic       bm_we,
  input  logic [7:0] bm_addr,
  input  logic       bm_data,
  input  logic       pos_valid,
  output logic       pos_ready,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  output logic [7:0] red_in,
  output logic [7:0] green_in,
  output logic [7:0] blue_in,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] H_VIS = 10'd640;
  localparam logic [9:0] V_VIS = 10'd480;
`ifdef SPRITE_SCALE2X_EN
  localparam logic [10:0] W = 11'd32;
`else
  localparam logic [10:0] W = 11'd16;
`endif

  logic [9:0]   r_s1_x, r_s1_y;
  logic [255:0] r_bitmap;
  logic [9:0]   r_act_x, r_act_y;
  logic [9:0]   r_sh_x, r_sh_y;
  logic         r_pending;
  logic         r_armed;
  logic [7:0]   r_frame;
  logic [7:0]   r_red, r_grn, r_blu;

  logic         w_commit, w_hs;
  logic [10:0]  w_x11, w_y11, w_ax11, w_ay11;
  logic         w_in_x, w_in_y, w_visible, w_bit;
  logic [9:0]   w_dx, w_dy;
  logic [3:0]   w_col, w_row;
  logic [7:0]   w_red, w_grn, w_blu;

  // Commit fires on the first next_y==480 after any other line, i.e. once per frame.
  assign w_commit = (next_y == V_VIS) && r_armed;
  assign w_hs     = pos_valid && !r_pending;

  // 11-bit compares so a sprite near the right/bottom edge never wraps to 0.
  assign w_x11  = {1'b0, r_s1_x};
  assign w_y11  = {1'b0, r_s1_y};
  assign w_ax11 = {1'b0, r_act_x};
  assign w_ay11 = {1'b0, r_act_y};
  assign w_in_x = (w_x11 >= w_ax11) && (w_x11 < w_ax11 + W);
  assign w_in_y = (w_y11 >= w_ay11) && (w_y11 < w_ay11 + W);
  assign w_visible = (r_s1_x < H_VIS) && (r_s1_y < V_VIS);

  assign w_dx = r_s1_x - r_act_x;
  assign w_dy = r_s1_y - r_act_y;
`ifdef SPRITE_SCALE2X_EN
  assign w_col = 4'(w_dx >> 1);
  assign w_row = 4'(w_dy >> 1);
`else
  assign w_col = 4'(w_dx);
  assign w_row = 4'(w_dy);
`endif
  assign w_bit = r_bitmap[{w_row, w_col}];

  always_comb begin
    w_red = 8'd0;
    w_grn = 8'd0;
    w_blu = 8'd0;
    if (w_visible) begin
      if (w_in_x && w_in_y && w_bit) begin
        w_red = spr_r;
        w_grn = spr_g;
        w_blu = spr_b;
      end else begin
        w_red = bg_r;
        w_grn = bg_g;
        w_blu = bg_b;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_s1_x <= 10'd0;
      r_s1_y <= 10'd0;
      r_red  <= 8'd0;
      r_grn  <= 8'd0;
      r_blu  <= 8'd0;
    end else begin
      r_s1_x <= next_x;
      r_s1_y <= next_y;
      r_red  <= w_red;
      r_grn  <= w_grn;
      r_blu  <= w_blu;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_bitmap <= '0;
    end else if (bm_we) begin
      r_bitmap[bm_addr] <= bm_data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_armed   <= 1'b0;
      r_frame   <= 8'd0;
      r_act_x   <= 10'd0;
      r_act_y   <= 10'd0;
      r_sh_x    <= 10'd0;
      r_sh_y    <= 10'd0;
      r_pending <= 1'b0;
    end else begin
      if (next_y != V_VIS)
        r_armed <= 1'b1;
      else if (w_commit)
        r_armed <= 1'b0;
      if (w_commit) begin
        r_frame <= r_frame + 8'd1;
        if (r_pending) begin
          r_act_x <= r_sh_x;
          r_act_y <= r_sh_y;
        end
      end
      // A capture on the commit edge stays pending; only the older value commits.
      if (w_hs) begin
        r_sh_x    <= pos_x;
        r_sh_y    <= pos_y;
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign pos_ready = !r_pending;
  assign red_in    = r_red;
  assign green_in  = r_grn;
  assign blue_in   = r_blu;
  assign frame_cnt = r_frame;

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// tb/tb_vga_sprite_renderer.sv - self-checking bench for vga_sprite_renderer
module tb_vga_sprite_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] next_x, next_y;
  logic [7:0] bg_r, bg_g, bg_b, spr_r, spr_g, spr_b;
  logic       bm_we;
  logic [7:0] bm_addr;
  logic       bm_data;
  logic       pos_valid;
  logic       pos_ready;
  logic [9:0] pos_x, pos_y;
  logic [7:0] red_in, green_in, blue_in, frame_cnt;

  int checks = 0;
  int failures = 0;
  bit started = 0;

  localparam logic [23:0] BG  = 24'h0A141E;
  localparam logic [23:0] SPR = 24'hFF0000;
`ifdef SPRITE_SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int SW = 16 * S;

  always #10 clk = ~clk;

  vga_sprite_renderer dut (
    .CLOCK_50(clk), .reset(reset),
    .next_x(next_x), .next_y(next_y),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .spr_r(spr_r), .spr_g(spr_g), .spr_b(spr_b),
    .bm_we(bm_we), .bm_addr(bm_addr), .bm_data(bm_data),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_x(pos_x), .pos_y(pos_y),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .frame_cnt(frame_cnt)
  );

  // Reference model: pixel rule from coordinates, plus frame/position bookkeeping.
  bit          m_bm [256];
  int          m_ax, m_ay, m_sx, m_sy, m_frame, m_qx, m_qy, m_prev_y;
  bit          m_pending, m_have_prev;
  logic [23:0] m_out = 24'd0;

  function automatic logic [23:0] colour_of(input int x, input int y);
    int idx;
    if (x >= 640 || y >= 480) return 24'd0;
    if (x >= m_ax && x < m_ax + SW && y >= m_ay && y < m_ay + SW) begin
      idx = ((y - m_ay) / S) * 16 + (x - m_ax) / S;
      if (m_bm[idx]) return {spr_r, spr_g, spr_b};
    end
    return {bg_r, bg_g, bg_b};
  endfunction

  always @(posedge clk) begin
    bit commit, hs;
    if (!reset) begin
      foreach (m_bm[i]) m_bm[i] = 1'b0;
      m_ax = 0; m_ay = 0; m_sx = 0; m_sy = 0; m_frame = 0;
      m_qx = 0; m_qy = 0; m_prev_y = 0; m_pending = 0; m_have_prev = 0;
      m_out = 24'd0;
    end else begin
      m_out  = colour_of(m_qx, m_qy);
      commit = (next_y == 480) && m_have_prev && (m_prev_y != 480);
      hs     = pos_valid && !m_pending;
      if (commit) begin
        if (m_pending) begin
          m_ax = m_sx;
          m_ay = m_sy;
        end
        m_frame   = (m_frame + 1) % 256;
        m_pending = 0;
      end
      if (hs) begin
        m_sx = pos_x;
        m_sy = pos_y;
        m_pending = 1;
      end
      if (bm_we) m_bm[bm_addr] = bm_data;
      m_prev_y = next_y;
      m_have_prev = 1;
      m_qx = next_x;
      m_qy = next_y;
    end
  end

  always @(negedge clk) begin
    logic [23:0] e_col;
    int          e_frame;
    logic        e_ready;
    if (started) begin
      e_col   = reset ? m_out : 24'd0;
      e_frame = reset ? m_frame : 0;
      e_ready = reset ? !m_pending : 1'b1;
      checks++;
      if ({red_in, green_in, blue_in} !== e_col) begin
        failures++;
        $display("FAIL model_colour t=%0t got=%06h exp=%06h", $time, {red_in, green_in, blue_in}, e_col);
      end
      checks++;
      if (int'(frame_cnt) != e_frame) begin
        failures++;
        $display("FAIL model_frame t=%0t got=%0d exp=%0d", $time, frame_cnt, e_frame);
      end
      checks++;
      if (pos_ready !== e_ready) begin
        failures++;
        $display("FAIL model_ready t=%0t got=%0b exp=%0b", $time, pos_ready, e_ready);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic px(input int x, input int y);
    next_x = 10'(x);
    next_y = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int x, input int y, input logic [23:0] e, input string name);
    px(x, y);
    px(x, y);
    chk(name, {8'd0, red_in, green_in, blue_in}, {8'd0, e});
  endtask

  task automatic bmw(input int addr, input logic d);
    bm_we = 1'b1;
    bm_addr = 8'(addr);
    bm_data = d;
    @(posedge clk);
    #1;
    bm_we = 1'b0;
  endtask

  task automatic hs(input int x, input int y);
    pos_valid = 1'b1;
    pos_x = 10'(x);
    pos_y = 10'(y);
    @(posedge clk);
    #1;
    pos_valid = 1'b0;
  endtask

  task automatic commit_frame();
    px(0, 0);
    px(0, 480);
  endtask

  initial begin
    reset = 1'b0;
    next_x = 10'd0; next_y = 10'd0;
    bg_r = 8'd10; bg_g = 8'd20; bg_b = 8'd30;
    spr_r = 8'd255; spr_g = 8'd0; spr_b = 8'd0;
    bm_we = 1'b0; bm_addr = 8'd0; bm_data = 1'b0;
    pos_valid = 1'b0; pos_x = 10'd0; pos_y = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    started = 1;
    chk("reset_colour", {8'd0, red_in, green_in, blue_in}, 32'd0);
    chk("reset_frame", 32'(frame_cnt), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_frame", 32'(frame_cnt), 32'd0);
    chk("post_reset_ready", 32'(pos_ready), 32'd1);
    probe(5, 5, BG, "bg_empty_bitmap");

    bmw(0, 1'b1);
    hs(100, 50);
    chk("ready_drop", 32'(pos_ready), 32'd0);
    commit_frame();
    chk("frame_1", 32'(frame_cnt), 32'd1);
    chk("ready_back", 32'(pos_ready), 32'd1);
    probe(100, 50, SPR, "spr_origin");
`ifdef SPRITE_SCALE2X_EN
    probe(101, 50, SPR, "spr_2x_right");
    probe(102, 50, BG, "bg_2x_next_bit");
`else
    probe(101, 50, BG, "bg_bit0_only");
    probe(116, 50, BG, "bg_past_width");
`endif
    probe(99, 50, BG, "bg_left_of_sprite");

    px(0, 10);
    hs(200, 200);
    chk("ready_pending", 32'(pos_ready), 32'd0);
    probe(100, 50, SPR, "old_pos_held");
    probe(200, 200, BG, "new_pos_not_yet");
    commit_frame();
    chk("frame_2", 32'(frame_cnt), 32'd2);
    chk("ready_after_commit", 32'(pos_ready), 32'd1);
    probe(200, 200, SPR, "new_pos_live");
    probe(100, 50, BG, "old_pos_gone");

    for (int i = 0; i < 256; i++) bmw(i, 1'b1);
    hs(630, 470);
    commit_frame();
    chk("frame_3", 32'(frame_cnt), 32'd3);
    probe(630, 470, SPR, "edge_corner");
    probe(639, 479, SPR, "edge_last_pixel");
    probe(640, 470, 24'd0, "x640_black");
    probe(0, 470, BG, "no_wrap_x0");
    probe(629, 470, BG, "left_of_edge_sprite");
    probe(635, 469, BG, "above_edge_sprite");

    px(0, 0);
    pos_valid = 1'b1; pos_x = 10'd300; pos_y = 10'd300;
    next_x = 10'd0; next_y = 10'd480;
    @(posedge clk);
    #1;
    pos_valid = 1'b0;
    chk("coincide_frame", 32'(frame_cnt), 32'd4);
    chk("coincide_pending", 32'(pos_ready), 32'd0);
    probe(300, 300, BG, "coincide_not_yet");
    probe(635, 475, SPR, "coincide_old_pos");
    commit_frame();
    chk("frame_5", 32'(frame_cnt), 32'd5);
    probe(300, 300, SPR, "coincide_next_frame");
    probe(635, 475, BG, "coincide_old_gone");

    hs(50, 50);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_drop_ready", 32'(pos_ready), 32'd1);
    chk("reset_drop_frame", 32'(frame_cnt), 32'd0);
    probe(0, 0, BG, "bitmap_cleared");
    bmw(0, 1'b1);
    commit_frame();
    chk("frame_after_reset", 32'(frame_cnt), 32'd1);
    probe(0, 0, SPR, "pos_reset_origin");
    probe(50, 50, BG, "pending_discarded");
`ifdef SPRITE_SCALE2X_EN
    probe(1, 1, SPR, "scale_block_corner");
    probe(2, 0, BG, "scale_next_bit");
`endif

    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 255; i++) commit_frame();
    chk("frame_255", 32'(frame_cnt), 32'd255);
    commit_frame();
    chk("frame_wrap", 32'(frame_cnt), 32'd0);
    px(0, 0);
    px(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
